// File: rtl/apb_master_pkg.sv
// Shared types for the APB requester: FSM state encoding, the transfer record
// carried from the command holding register into the bus phase, and bus widths.
package apb_master_pkg;

    // Default APB bus widths used by the transfer record and the module parameters.
    localparam int unsigned APB_ADDR_WIDTH = 32;
    localparam int unsigned APB_DATA_WIDTH = 32;

    // Bus phase of the requester.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    // One queued or in-flight APB transfer.
    typedef struct packed {
        logic                      write;
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic [APB_DATA_WIDTH-1:0] wdata;
    } apb_xfer_t;

    // Build a transfer record; read transfers carry all-zero write data so
    // PWDATA is driven low for the whole read.
    function automatic apb_xfer_t make_xfer(
        input logic                      write,
        input logic [APB_ADDR_WIDTH-1:0] addr,
        input logic [APB_DATA_WIDTH-1:0] wdata
    );
        apb_xfer_t x;
        x.write = write;
        x.addr  = addr;
        x.wdata = write ? wdata : '0;
        return x;
    endfunction

endpackage

// File: rtl/apb_cmd_buf.sv
// One-entry command holding register in front of the APB requester FSM.
// cmd_ready is a flop equal to "no command held"; it stays low during reset
// and rises on the first clock edge after reset is released.
module apb_cmd_buf
    import apb_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH
) (
    input  logic                  PCLK,
    input  logic                  PRESET_N,
    input  logic                  cmd_valid,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic                  take,
    output logic                  cmd_ready,
    output logic                  pending_valid,
    output apb_xfer_t             pending
);

    logic accept;
    logic pending_valid_nxt;

    // Occupancy after this edge: a new command fills the slot, the FSM draining
    // it empties the slot.
    always_comb begin
        accept            = cmd_valid & cmd_ready;
        pending_valid_nxt = accept | (pending_valid & ~take);
    end

    // Holding register, its valid flag and the registered ready.
    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            pending_valid <= 1'b0;
            cmd_ready     <= 1'b0;
            pending       <= '0;
        end else begin
            pending_valid <= pending_valid_nxt;
            cmd_ready     <= ~pending_valid_nxt;
            if (accept) begin
                pending <= make_xfer(cmd_write, cmd_addr, cmd_wdata);
            end
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB requester: accepts commands through a one-entry holding register, runs
// them as SETUP/ACCESS bus transfers, aborts ACCESS phases that exceed the
// wait-state budget and reports each completion with a one-cycle response.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET_N,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PSEL,
    output logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    // The counter only has to reach TIMEOUT_CYCLES-1: the TIMEOUT_CYCLES-th
    // stalled ACCESS cycle is detected by comparison, not by counting into it.
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    apb_state_t      state;
    apb_state_t      state_nxt;
    apb_xfer_t       xfer;
    apb_xfer_t       pending;
    logic            pending_valid;
    logic            take;
    logic            complete;
    logic            timed_out;
    logic [TO_W-1:0] tmo_cnt;

    apb_cmd_buf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmd_buf (
        .PCLK          (PCLK),
        .PRESET_N      (PRESET_N),
        .cmd_valid     (cmd_valid),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .take          (take),
        .cmd_ready     (cmd_ready),
        .pending_valid (pending_valid),
        .pending       (pending)
    );

    // Completion and abort qualifiers; PREADY is only looked at in ACCESS and a
    // ready completer wins over an expiring wait budget.
    always_comb begin
        complete  = (state == ST_ACCESS) && PREADY;
        timed_out = (TIMEOUT_CYCLES != 0) && (state == ST_ACCESS) && !PREADY
                    && (tmo_cnt == TO_LAST);
        take      = pending_valid && ((state == ST_IDLE) || complete);
    end

    // State register.
    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a held command at completion goes straight to SETUP.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (pending_valid) begin
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (complete) begin
                    state_nxt = pending_valid ? ST_SETUP : ST_IDLE;
                end else if (timed_out) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bus outputs: phase strobes from the state, payload from the transfer register.
    always_comb begin
        PSEL    = (state == ST_SETUP) || (state == ST_ACCESS);
        PENABLE = (state == ST_ACCESS);
        PADDR   = xfer.addr;
        PWRITE  = xfer.write;
        PWDATA  = xfer.wdata;
    end

    // Transfer register, loaded whenever the held command starts its SETUP.
    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            xfer <= '0;
        end else if (take) begin
            xfer <= pending;
        end
    end

    // Wait-state counter: restarts in SETUP, counts stalled ACCESS cycles.
    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            tmo_cnt <= '0;
        end else if (state == ST_SETUP) begin
            tmo_cnt <= '0;
        end else if ((state == ST_ACCESS) && !PREADY) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Response register: one-cycle pulse after completion or abort.
    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            rsp_valid   <= complete | timed_out;
            rsp_timeout <= timed_out;
            rsp_rdata   <= (complete && !xfer.write) ? PRDATA : '0;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed transfers followed by random
// commands, completer wait states and resets, all compared cycle by cycle
// against a transaction-queue model of the requester.
module tb_apb_master;

    localparam int TO = 4;

    typedef struct {
        bit        write;
        bit [31:0] addr;
        bit [31:0] wdata;
    } cmd_t;

    logic        PCLK;
    logic        PRESET_N;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;

    apb_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK        (PCLK),
        .PRESET_N    (PRESET_N),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .PADDR       (PADDR),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: phase 0=idle, 1=setup, 2=access; queue of held commands.
    int        m_phase = 0;
    cmd_t      m_pend[$];
    cmd_t      m_cur;
    int        m_acc = 0;
    bit        m_rv = 0;
    bit [31:0] m_rdata = 0;
    bit        m_rto = 0;
    bit        m_ready = 0;
    bit        m_accept = 0;
    bit        m_fresh = 1;

    // Completer policy: 0 ready at once, 1 ready after wait_n stalls,
    // 2 never ready, 3 random.
    int mode = 0;
    int wait_n = 0;
    bit prdata_fixed = 0;

    bit        prev_sel = 0;
    bit [64:0] prev_bus = '0;
    int        obs_acc = 0;

    // Predict the effect of the coming rising edge from the inputs now driven.
    task automatic model_edge();
        cmd_t c;
        bit   acc_now;
        m_accept = 0;
        if (!PRESET_N) begin
            m_phase = 0;
            m_pend.delete();
            m_cur   = '{write: 0, addr: 0, wdata: 0};
            m_acc   = 0;
            m_rv    = 0;
            m_rdata = 0;
            m_rto   = 0;
            m_ready = 0;
            m_fresh = 1;
        end else begin
            acc_now = cmd_valid && m_ready;
            m_rv    = 0;
            m_rdata = 0;
            m_rto   = 0;
            case (m_phase)
                0: begin
                    if (m_pend.size() > 0) begin
                        m_cur   = m_pend.pop_front();
                        m_phase = 1;
                        m_fresh = 0;
                    end
                end
                1: begin
                    m_phase = 2;
                    m_acc   = 1;
                end
                default: begin
                    if (PREADY) begin
                        m_rv    = 1;
                        m_rdata = m_cur.write ? 32'h0 : PRDATA;
                        if (m_pend.size() > 0) begin
                            m_cur   = m_pend.pop_front();
                            m_phase = 1;
                        end else begin
                            m_phase = 0;
                        end
                    end else if (m_acc == TO) begin
                        m_rv    = 1;
                        m_rto   = 1;
                        m_phase = 0;
                    end else begin
                        m_acc++;
                    end
                end
            endcase
            if (acc_now) begin
                c.write = cmd_write;
                c.addr  = cmd_addr;
                c.wdata = cmd_write ? cmd_wdata : 32'h0;
                m_pend.push_back(c);
                m_accept = 1;
            end
            m_ready = (m_pend.size() == 0);
        end
    endtask

    task automatic compare_cycle();
        check_eq("psel_known", 96'($isunknown({PSEL, PENABLE})), 96'(0));
        check_eq("psel", 96'(PSEL), 96'(m_phase != 0));
        check_eq("penable", 96'(PENABLE), 96'(m_phase == 2));
        check_eq("cmd_ready", 96'(cmd_ready), 96'(m_ready));
        check_eq("rsp_valid", 96'(rsp_valid), 96'(m_rv));
        if (m_rv) begin
            check_eq("rsp_rdata", 96'(rsp_rdata), 96'(m_rdata));
            check_eq("rsp_timeout", 96'(rsp_timeout), 96'(m_rto));
        end
        if (m_phase != 0 || m_fresh) begin
            check_eq("paddr", 96'(PADDR), 96'(m_cur.addr));
            check_eq("pwrite", 96'(PWRITE), 96'(m_cur.write));
            check_eq("pwdata", 96'(PWDATA), 96'(m_cur.wdata));
        end
        if (PSEL && PENABLE && prev_sel) begin
            check_eq("bus_stable", 96'({PADDR, PWRITE, PWDATA}), 96'(prev_bus));
        end
        prev_sel = PSEL;
        prev_bus = {PADDR, PWRITE, PWDATA};
        if (PSEL && !PENABLE) obs_acc = 0;
        if (PENABLE) obs_acc++;
    endtask

    task automatic drive_completer();
        PRDATA = prdata_fixed ? 32'h1234_5678 : $urandom;
        if (m_phase == 2) begin
            case (mode)
                0:       PREADY = 1'b1;
                1:       PREADY = (m_acc > wait_n);
                2:       PREADY = 1'b0;
                default: PREADY = ($urandom_range(0, 2) == 0);
            endcase
        end else begin
            PREADY = ($urandom_range(0, 1) == 1);
        end
    endtask

    // One clock: predict the edge, let it happen, compare, drive the completer.
    task automatic step();
        model_edge();
        @(negedge PCLK);
        compare_cycle();
        drive_completer();
    endtask

    task automatic send(input bit w, input bit [31:0] a, input bit [31:0] d);
        bit got = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 50 && !got; i++) begin
            step();
            got = m_accept;
        end
        cmd_valid = 1'b0;
        check_eq("send_accept", 96'(got), 96'(1));
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 100 && !rsp_valid; i++) begin
            step();
        end
        check_eq("rsp_arrived", 96'(rsp_valid), 96'(1));
    endtask

    initial begin
        PRESET_N  = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PREADY    = 1'b0;
        PRDATA    = '0;
        @(negedge PCLK);

        // Reset and release.
        repeat (3) step();
        check_eq("rst_psel", 96'({PSEL, PENABLE}), 96'(0));
        check_eq("rst_ready", 96'(cmd_ready), 96'(0));
        PRESET_N = 1'b1;
        step();
        check_eq("ready_after_rst", 96'(cmd_ready), 96'(1));

        // Write with zero wait states.
        mode = 0;
        send(1'b1, 32'h10, 32'hDEAD_BEEF);
        wait_rsp();
        check_eq("wr_access_cycles", 96'(obs_acc), 96'(1));
        check_eq("wr_rdata", 96'(rsp_rdata), 96'(0));
        check_eq("wr_timeout", 96'(rsp_timeout), 96'(0));
        repeat (2) step();

        // Read with three wait states.
        mode = 1;
        wait_n = 3;
        prdata_fixed = 1;
        send(1'b0, 32'h20, 32'hFFFF_FFFF);
        wait_rsp();
        check_eq("rd_access_cycles", 96'(obs_acc), 96'(4));
        check_eq("rd_rdata", 96'(rsp_rdata), 96'(32'h1234_5678));
        prdata_fixed = 0;
        repeat (2) step();

        // Back-to-back: second command held while the first is in ACCESS.
        mode = 1;
        wait_n = 2;
        send(1'b1, 32'h40, 32'h0000_00AA);
        send(1'b0, 32'h44, 32'h0);
        for (int i = 0; i < 30 && !(PENABLE && PREADY); i++) begin
            step();
        end
        step();
        check_eq("b2b_setup", 96'({PSEL, PENABLE}), 96'(2'b10));
        check_eq("b2b_paddr", 96'(PADDR), 96'(32'h44));
        mode = 0;
        repeat (8) step();

        // Timeout with PREADY held low.
        mode = 2;
        send(1'b0, 32'h30, 32'h0);
        wait_rsp();
        check_eq("to_flag", 96'(rsp_timeout), 96'(1));
        check_eq("to_rdata", 96'(rsp_rdata), 96'(0));
        check_eq("to_psel", 96'(PSEL), 96'(0));
        check_eq("to_access_cycles", 96'(obs_acc), 96'(TO));
        repeat (2) step();

        // Reset during ACCESS with a command held.
        send(1'b1, 32'h50, 32'h5555_5555);
        send(1'b1, 32'h54, 32'h6666_6666);
        PRESET_N = 1'b0;
        step();
        check_eq("rst_mid_psel", 96'({PSEL, PENABLE}), 96'(0));
        check_eq("rst_mid_rsp", 96'(rsp_valid), 96'(0));
        PRESET_N = 1'b1;
        step();
        check_eq("rst_mid_ready", 96'(cmd_ready), 96'(1));
        mode = 0;
        repeat (6) step();

        // Random traffic, wait states and occasional reset.
        mode = 3;
        for (int n = 0; n < 2000; n++) begin
            step();
            if (!cmd_valid || m_accept) begin
                cmd_valid = ($urandom_range(0, 1) == 1);
                cmd_write = ($urandom_range(0, 1) == 1);
                cmd_addr  = $urandom;
                cmd_wdata = $urandom;
            end
            PRESET_N = ($urandom_range(0, 199) != 0);
        end

        // Drain.
        cmd_valid = 1'b0;
        PRESET_N  = 1'b1;
        mode = 0;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, APB address width (matches `ADDR_WIDTH).
REQ-002 Parameter DATA_WIDTH, default 32, APB data width (matches `DATA_WIDTH).
REQ-003 Parameter TIMEOUT_CYCLES, default 16, max ACCESS cycles waiting on PREADY; 0 disables timeout.
REQ-004 PCLK  in  1  sole clock; all state updates on rising edge.
REQ-005 PRESET_N  in  1  reset, synchronous, active-low.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accept; transfer on cmd_valid & cmd_ready at rising edge.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_WIDTH  target address.
REQ-010 cmd_wdata  in  DATA_WIDTH  write data (ignored for reads).
REQ-011 rsp_valid  out  1  one-cycle completion pulse, no backpressure.
REQ-012 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
REQ-013 rsp_timeout  out  1  qualifies rsp_valid: transfer aborted on timeout.
REQ-014 PADDR, PWRITE, PWDATA, PSEL, PENABLE  out  ADDR_WIDTH/1/DATA_WIDTH/1/1  APB requester signals.
REQ-015 PRDATA, PREADY  in  DATA_WIDTH/1  APB completer signals.

Function
REQ-016 Command path SHALL be a 1-entry holding register; cmd_ready = !pending_valid, registered.
REQ-017 FSM states SHALL be IDLE (PSEL=0, PENABLE=0), SETUP (PSEL=1, PENABLE=0), ACCESS (PSEL=1, PENABLE=1).
REQ-018 IDLE -> SETUP at the edge where pending_valid=1; pending entry moves into the transfer register at that edge, and pending_valid clears unless a new command is accepted at the same edge.
REQ-019 SETUP SHALL last exactly one cycle, then ACCESS.
REQ-020 PADDR, PWRITE, PWDATA SHALL come from the transfer register and stay constant from SETUP through last ACCESS cycle; PWDATA = 0 for reads.
REQ-021 ACCESS with PREADY=1: transfer completes at that edge; next state SETUP if pending_valid=1 (back-to-back, no IDLE), else IDLE.
REQ-022 On completion, rsp_valid=1 for exactly the next cycle; rsp_rdata = PRDATA sampled at the completing edge for reads, 0 for writes; rsp_timeout=0.
REQ-023 Timeout counter SHALL clear on SETUP and increment each ACCESS cycle with PREADY=0.
REQ-024 If TIMEOUT_CYCLES>0 and the TIMEOUT_CYCLES-th ACCESS cycle sees PREADY=0: abort to IDLE at that edge; next cycle rsp_valid=1, rsp_timeout=1, rsp_rdata=0.
REQ-025 PREADY=1 in the same cycle timeout would fire SHALL complete normally (REQ-021 wins).
REQ-026 Command accepted at the completing edge SHALL be held in pending and start in SETUP one cycle later via IDLE.
REQ-027 PREADY and PRDATA SHALL be ignored outside ACCESS.
REQ-028 PSEL and PENABLE SHALL never be X after reset; PENABLE=1 only when PSEL=1.

Reset
REQ-029 While PRESET_N=0 at an edge: state=IDLE, PSEL=PENABLE=0, PADDR=PWDATA=0, PWRITE=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, pending and timeout counter cleared.
REQ-030 cmd_ready SHALL be 1 in the first cycle after PRESET_N returns high.
REQ-031 Reset mid-transfer SHALL abort with no rsp_valid and discard pending command.

Structure
REQ-032 Package apb_master_pkg SHALL hold the FSM state enum typedef and the transfer-record struct (write, addr, wdata); widths from apb_defines.svh.
REQ-033 Holding register SHALL be sub-module apb_cmd_buf; FSM, timeout counter and response register stay in apb_master.

Verification
REQ-034 Write 0x10<=0xDEADBEEF, PREADY=1 in first ACCESS -> 1 SETUP, 1 ACCESS, PWDATA stable, rsp_valid pulse with rsp_rdata=0.
REQ-035 Read 0x20, PREADY low 3 ACCESS cycles, PRDATA=0x12345678 on 4th -> 4 ACCESS cycles, rsp_rdata=0x12345678, PADDR stable throughout.
REQ-036 Two commands queued (second in pending before first completes) -> ACCESS of first followed directly by SETUP of second, no IDLE cycle.
REQ-037 TIMEOUT_CYCLES=4, PREADY held 0 -> abort after 4th ACCESS cycle, rsp_timeout=1, rsp_rdata=0, PSEL=0 next cycle.
REQ-038 PRESET_N low during ACCESS with a pending command -> PSEL/PENABLE 0 next cycle, no rsp_valid, cmd_ready=1 one cycle after release.
REQ-039 Bound checker asserting REQ-020/REQ-028 protocol stability SHALL be active in all scenarios.
